// File: rtl/stack_pc_param.sv
// Program counter with an integrated return-address stack.
// The PC is NIBBLES x 4 bits wide. Software reads and writes it one nibble at a
// time over the 4-bit internal bus, and the fetch unit sees the full width on pc_out.
// The stack is a DEPTH-entry circular buffer. It either saturates and raises
// sticky flags (WRAP=0), or it overwrites the oldest entry when full (WRAP=1).
module stack_pc_param #(
  parameter int NIBBLES = 3,
  parameter int DEPTH   = 8,
  parameter int WRAP    = 0,
  parameter int SEL_W   = 2,
  localparam int PC_W   = 4 * NIBBLES,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             pc_inc,
  input  logic             pc_load,
  input  logic [SEL_W-1:0] pc_sel,
  input  logic [3:0]       data_in,
  input  logic             err_clr,
  output logic [3:0]       data_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [CNT_W-1:0] sp_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // ptr_q points at the slot the next push writes.
  // In a full wrapped stack, that slot is also the oldest entry.
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  mem_q [DEPTH];

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [PC_W-1:0]  mem_wdata;
  logic [PTR_W-1:0] top_idx;
  logic             full, empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_W'(1);
  endfunction

  assign full        = (cnt_q == CNT_DEPTH);
  assign empty       = (cnt_q == '0);
  assign top_idx     = ptr_dec(ptr_q);
  assign pc_out      = pc_q;
  assign sp_count    = cnt_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // Nibble read mux; selections past the last nibble read as zero.
  always_comb begin
    data_out = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (pc_sel == SEL_W'(i)) data_out = pc_q[4*i +: 4];
    end
  end

  // One action per cycle: load > swap > push > pop > increment.
  // err_clr is applied first, so an error raised in the same cycle still sets its flag.
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ovf_d     = err_clr ? 1'b0 : ovf_q;
    unf_d     = err_clr ? 1'b0 : unf_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = pc_q;
    if (pc_load) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (pc_sel == SEL_W'(i)) pc_d[4*i +: 4] = data_in;
      end
    end else if (push && pop && !empty) begin
      pc_d      = mem_q[top_idx];
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (push) begin
      if (!full) begin
        mem_we = 1'b1;
        ptr_d  = ptr_inc(ptr_q);
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
        if (WRAP != 0) begin
          mem_we = 1'b1;
          ptr_d  = ptr_inc(ptr_q);
        end
      end
    end else if (pop) begin
      if (!empty) begin
        pc_d  = mem_q[top_idx];
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (pc_inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // PC, stack pointer and flag registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage has no reset.
  // Its contents only become meaningful once they have been pushed.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_stack_pc_param.sv
// Directed bench for stack_pc_param.
// Two instances share the same stimulus: an 8-deep saturating stack and a
// 4-deep circular stack.
module tb_stack_pc_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       push = 1'b0, pop = 1'b0, pc_inc = 1'b0, pc_load = 1'b0, err_clr = 1'b0;
  logic [1:0] pc_sel = 2'd0;
  logic [3:0] data_in = 4'h0;

  logic [3:0]  d_out8, d_out4;
  logic [11:0] pc8, pc4;
  logic [3:0]  sp8;
  logic [2:0]  sp4;
  logic        full8, empty8, ovf8, unf8;
  logic        full4, empty4, ovf4, unf4;

  int passed = 0;
  int total  = 0;

  stack_pc_param #(.NIBBLES(3), .DEPTH(8), .WRAP(0), .SEL_W(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_sel(pc_sel), .data_in(data_in), .err_clr(err_clr),
    .data_out(d_out8), .pc_out(pc8), .sp_count(sp8), .stack_full(full8),
    .stack_empty(empty8), .overflow(ovf8), .underflow(unf8)
  );

  stack_pc_param #(.NIBBLES(3), .DEPTH(4), .WRAP(1), .SEL_W(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_sel(pc_sel), .data_in(data_in), .err_clr(err_clr),
    .data_out(d_out4), .pc_out(pc4), .sp_count(sp4), .stack_full(full4),
    .stack_empty(empty4), .overflow(ovf4), .underflow(unf4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; err_clr = 1'b0;
  endtask

  task automatic load_pc(input logic [11:0] v);
    logic [11:0] t;
    t = v;
    idle();
    for (int i = 0; i < 3; i++) begin
      pc_load = 1'b1; pc_sel = 2'(i); data_in = t[4*i +: 4];
      tick();
    end
    pc_load = 1'b0; pc_sel = 2'd0;
  endtask

  task automatic do_op(input logic p, input logic q, input logic inc, input logic clr);
    push = p; pop = q; pc_inc = inc; err_clr = clr;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset, then load the PC one nibble at a time.
    do_reset();
    check("rst_pc", pc8, 12'h000);
    check("rst_sp", sp8, 4'd0);
    check("rst_empty", empty8, 1'b1);
    check("rst_flags", {ovf8, unf8}, 2'b00);
    load_pc(12'h3A5);
    check("load_pc", pc8, 12'h3A5);
    pc_sel = 2'd0; #1 check("dout_n0", d_out8, 4'h5);
    pc_sel = 2'd1; #1 check("dout_n1", d_out8, 4'hA);
    pc_sel = 2'd2; #1 check("dout_n2", d_out8, 4'h3);
    pc_sel = 2'd3; #1 check("dout_n3", d_out8, 4'h0);
    pc_load = 1'b1; data_in = 4'hF; tick(); idle();
    check("load_sel3_noop", pc8, 12'h3A5);
    pc_sel = 2'd0;

    // Increment with a carry across nibbles, and with wrap-around to zero.
    load_pc(12'h0FF);
    do_op(0, 0, 1, 0);
    check("inc_carry", pc8, 12'h100);
    load_pc(12'hFFF);
    do_op(0, 0, 1, 0);
    check("inc_wrap", pc8, 12'h000);
    check("inc_wrap_flags", {ovf8, unf8}, 2'b00);

    // Nested calls until the saturating stack is full.
    for (int k = 1; k <= 8; k++) begin
      load_pc(12'(k * 16));
      do_op(1, 0, 0, 0);
    end
    check("push8_sp", sp8, 4'd8);
    check("push8_full", full8, 1'b1);
    check("push8_pc", pc8, 12'h080);
    do_op(1, 0, 0, 0);
    check("push9_ovf", ovf8, 1'b1);
    check("push9_sp", sp8, 4'd8);
    for (int k = 8; k >= 1; k--) begin
      do_op(0, 1, 0, 0);
      check("pop_pc", pc8, 12'(k * 16));
    end
    check("pop8_empty", empty8, 1'b1);
    do_op(0, 1, 0, 0);
    check("pop9_unf", unf8, 1'b1);
    check("pop9_pc", pc8, 12'h010);
    do_op(0, 0, 0, 1);
    check("errclr", {ovf8, unf8}, 2'b00);

    // Swap, then priority when several operations are requested together.
    load_pc(12'h123);
    do_op(1, 0, 0, 0);
    load_pc(12'h456);
    do_op(1, 1, 0, 0);
    check("swap_pc", pc8, 12'h123);
    check("swap_sp", sp8, 4'd1);
    pc_load = 1'b1; pc_sel = 2'd0; data_in = 4'h7; push = 1'b1; pc_inc = 1'b1;
    tick(); idle();
    check("prio_pc", pc8, 12'h127);
    check("prio_sp", sp8, 4'd1);
    do_op(0, 1, 0, 0);
    check("swap_top", pc8, 12'h456);
    check("swap_pop_sp", sp8, 4'd0);
    do_op(0, 1, 0, 1);
    check("clr_vs_set", unf8, 1'b1);
    do_op(0, 0, 0, 1);

    // Reset in the middle of a push, with overflow already set.
    for (int k = 0; k < 9; k++) do_op(1, 0, 0, 0);
    check("pre_rst_ovf", ovf8, 1'b1);
    reset_n = 1'b0; push = 1'b1;
    tick(); idle(); reset_n = 1'b1;
    check("midrst_pc", pc8, 12'h000);
    check("midrst_sp", sp8, 4'd0);
    check("midrst_ovf", ovf8, 1'b0);
    do_op(0, 1, 0, 0);
    check("midrst_unf", unf8, 1'b1);

    // Circular stack: six pushes into four slots keep the newest four entries.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      load_pc(12'(k));
      do_op(1, 0, 0, 0);
    end
    check("wrap_sp", sp4, 3'd4);
    check("wrap_full", full4, 1'b1);
    check("wrap_ovf", ovf4, 1'b1);
    for (int k = 6; k >= 3; k--) begin
      do_op(0, 1, 0, 0);
      check("wrap_pop", pc4, 12'(k));
    end
    do_op(0, 1, 0, 0);
    check("wrap_unf", unf4, 1'b1);
    check("wrap_unf_pc", pc4, 12'h003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
